// File: rtl/qsys_pio_pkg.sv
// rtl/qsys_pio_pkg.sv - register map and edge-type constants for the input PIO
package qsys_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_debounce.sv
// rtl/pio_in_debounce.sv - one input bit: 2-FF synchroniser followed by a stability counter
module pio_in_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic deb
);

    logic sync1, sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or posedge reset) begin
                if (reset) deb <= 1'b0;
                else       deb <= sync2;
            end
        end else begin : g_count
            localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt;

            // Any return to the accepted level restarts the count, so glitches never accumulate.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt <= '0;
                    deb <= 1'b0;
                end else if (sync2 == deb) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    deb <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/qsys_pio_in_irq.sv
// rtl/qsys_pio_in_irq.sv - Avalon-MM input PIO with debounce, sticky edge capture and level irq
module qsys_pio_in_irq
    import qsys_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int          EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] deb, deb_d, rise, fall, edges, clr;
    logic [WIDTH-1:0] edge_capture, irq_mask;
    logic             wr;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .din  (in_port[i]),
            .deb  (deb[i])
        );
    end

    assign wr   = chipselect && !write_n;
    assign rise = deb & ~deb_d;
    assign fall = ~deb & deb_d;
    assign clr  = (wr && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        edges = rise;
        case (EDGE_TYPE)
            EDGE_RISE: edges = rise;
            EDGE_FALL: edges = fall;
            EDGE_ANY:  edges = rise | fall;
            default:   edges = rise;
        endcase
    end

    // A new edge is OR'd in after the clear so it survives a same-cycle W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_d        <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
        end else begin
            deb_d        <= deb;
            edge_capture <= (edge_capture & ~clr) | edges;
            if (wr && address == ADDR_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0] = deb;
            ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_capture;
            default:       readdata = '0;
        endcase
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_qsys_pio_in_irq.sv
// tb/tb_qsys_pio_in_irq.sv - directed scoreboard bench for rising, falling and any-edge PIO variants
`timescale 1ns/100ps
module tb_qsys_pio_in_irq;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   address = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = 32'd0;
    logic [W-1:0] in_port = '0;
    logic [31:0]  rdata [3];
    logic         irq_v [3];

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    qsys_pio_in_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[0]), .in_port(in_port), .irq(irq_v[0]));
    qsys_pio_in_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[1]), .in_port(in_port), .irq(irq_v[1]));
    qsys_pio_in_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[2]), .in_port(in_port), .irq(irq_v[2]));

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic rd_chk(input int d, input logic [1:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back('{tag, exp});
        address = a;
        #1;
        compare(rdata[d]);
    endtask

    task automatic irq_chk(input int d, input logic exp, input string tag);
        exp_q.push_back('{tag, {31'd0, exp}});
        #1;
        compare({31'd0, irq_v[d]});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] data);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = data;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        tick(2);
        reset = 1'b0;

        // reset state
        rd_chk(0, 2'd0, 32'h0, "rst_data");
        rd_chk(0, 2'd1, 32'h0, "rst_rsvd");
        rd_chk(0, 2'd2, 32'h0, "rst_mask");
        rd_chk(0, 2'd3, 32'h0, "rst_ecap");
        irq_chk(0, 1'b0, "rst_irq");

        // debounce latency: new value at edge 2+D, not before
        in_port = 4'b0101;
        tick(5);
        rd_chk(0, 2'd0, 32'h0, "lat_data_e5");
        tick();
        rd_chk(0, 2'd0, 32'h5, "lat_data_e6");
        rd_chk(0, 2'd3, 32'h0, "lat_ecap_e6");
        tick();
        rd_chk(0, 2'd3, 32'h5, "lat_ecap_e7");
        rd_chk(1, 2'd3, 32'h0, "lat_ecap_fall");
        rd_chk(2, 2'd3, 32'h5, "lat_ecap_any");
        wr(2'd3, 32'hF);
        rd_chk(0, 2'd3, 32'h0, "w1c_all");

        // glitch shorter than D is rejected, a held input is accepted
        in_port = 4'b0111;
        tick(3);
        in_port = 4'b0101;
        tick(8);
        rd_chk(0, 2'd0, 32'h5, "glitch_data");
        rd_chk(0, 2'd3, 32'h0, "glitch_ecap");
        in_port = 4'b0111;
        tick(7);
        rd_chk(0, 2'd0, 32'h7, "held_data");
        rd_chk(0, 2'd3, 32'h2, "held_ecap");
        irq_chk(0, 1'b0, "held_irq_unmasked");

        // irq follows edge_capture & mask, W1C drops it
        wr(2'd3, 32'hF);
        wr(2'd2, 32'h2);
        rd_chk(0, 2'd2, 32'h2, "mask_rb");
        in_port = 4'b0101;
        tick(7);
        wr(2'd3, 32'hF);
        in_port = 4'b0111;
        tick(6);
        rd_chk(0, 2'd3, 32'h0, "irq_pre_ecap");
        irq_chk(0, 1'b0, "irq_pre");
        tick();
        rd_chk(0, 2'd3, 32'h2, "irq_ecap");
        irq_chk(0, 1'b1, "irq_set");
        wr(2'd3, 32'h2);
        rd_chk(0, 2'd3, 32'h0, "irq_w1c_ecap");
        irq_chk(0, 1'b0, "irq_cleared");

        // W1C racing a new edge on bit 0: set wins
        in_port = 4'b1110;
        tick(7);
        rd_chk(0, 2'd3, 32'h8, "race_pre_ecap");
        in_port = 4'b1111;
        tick(6);
        rd_chk(0, 2'd0, 32'hF, "race_data");
        rd_chk(0, 2'd3, 32'h8, "race_pre_edge");
        wr(2'd3, 32'hF);
        rd_chk(0, 2'd3, 32'h1, "race_set_wins");
        irq_chk(0, 1'b0, "race_irq");

        // falling-edge and any-edge variants on bit 2
        wr(2'd3, 32'hF);
        in_port = 4'b1011;
        tick(7);
        rd_chk(1, 2'd3, 32'h4, "fall_ecap");
        rd_chk(2, 2'd3, 32'h4, "any_fall_ecap");
        rd_chk(0, 2'd3, 32'h0, "rise_ignores_fall");
        wr(2'd3, 32'hF);
        in_port = 4'b1111;
        tick(7);
        rd_chk(2, 2'd3, 32'h4, "any_rise_ecap");
        rd_chk(1, 2'd3, 32'h0, "fall_ignores_rise");

        // async reset mid-debounce
        wr(2'd2, 32'hF);
        wr(2'd3, 32'hF);
        in_port = 4'b1110;
        tick(4);
        rd_chk(0, 2'd0, 32'hF, "mid_deb_data");
        #2;
        reset = 1'b1;
        rd_chk(0, 2'd0, 32'h0, "arst_data");
        rd_chk(0, 2'd2, 32'h0, "arst_mask");
        rd_chk(0, 2'd3, 32'h0, "arst_ecap");
        irq_chk(0, 1'b0, "arst_irq");
        tick();
        reset = 1'b0;
        tick(6);
        rd_chk(0, 2'd0, 32'hE, "post_rst_data");
        rd_chk(0, 2'd3, 32'h0, "post_rst_ecap_pre");
        tick();
        rd_chk(0, 2'd3, 32'hE, "post_rst_ecap");
        wr(2'd3, 32'hE);
        tick(10);
        rd_chk(0, 2'd3, 32'h0, "post_rst_single");
        rd_chk(0, 2'd1, 32'h0, "rsvd_read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
